rx_correlator_ctrl: RTL and testbench



---
 rtl/rx_correlator_ctrl_if.sv | 38 +++
 rtl/rx_correlator_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rx_correlator_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_correlator_ctrl_if.sv
// rx_correlator_ctrl_if: detection report channel from the correlator controller to the symbol decoder.
//   odet_valid      report valid (master -> slave)
//   idet_ready      decoder accepts the report (slave -> master)
//   odet_index      winning sequence index
//   odet_mag        winning magnitude
//   odet_sign       1 = positive winning correlation
//   odet_hit        report qualifies as a detection
//   odet_second_mag second-best magnitude (only with RX_CORR_CTRL_PEAK_RATIO_EN defined)
interface rx_correlator_ctrl_if #(
    parameter int IW = 4,
    parameter int MW = 40
);
    logic          odet_valid;
    logic          idet_ready;
    logic [IW-1:0] odet_index;
    logic [MW-1:0] odet_mag;
    logic          odet_sign;
    logic          odet_hit;
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
    logic [MW-1:0] odet_second_mag;
`endif

    modport master (
        output odet_valid, odet_index, odet_mag, odet_sign, odet_hit,
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
        output odet_second_mag,
`endif
        input  idet_ready
    );

    modport slave (
        input  odet_valid, odet_index, odet_mag, odet_sign, odet_hit,
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
        input  odet_second_mag,
`endif
        output idet_ready
    );
endinterface

// File: rtl/rx_correlator_ctrl.sv
// rx_correlator_ctrl: triggers the correlator bank, waits out accumulation, scans all sequences for the strongest peak and reports it.
//   crx_clk / rrx_rst  clock, synchronous active-high reset
//   erx_en             enable; low behaves as reset
//   isample_valid      new sample window pulse
//   onew_sample_trig   one-clock trigger to the correlator
//   oseq_sel           result mux select (0 outside the scan)
//   icorr_value        signed correlation of oseq_sel (same cycle)
//   ithreshold         magnitude detection threshold
//   obusy              controller not idle
//   ooverrun           sticky dropped-sample flag, cleared by iclr_overrun
//   det                report channel (rx_correlator_ctrl_if master)
//   Optional: define RX_CORR_CTRL_PEAK_RATIO_EN to also require best >= 2*second-best and export odet_second_mag.
module rx_correlator_ctrl #(
    parameter int SEQ_COUNT  = 16,
    parameter int CORR_WIDTH = 41,
    parameter int ACC_CYCLES = 64
) (
    input  logic                         crx_clk,
    input  logic                         rrx_rst,
    input  logic                         erx_en,
    input  logic                         isample_valid,
    output logic                         onew_sample_trig,
    output logic [$clog2(SEQ_COUNT)-1:0] oseq_sel,
    input  logic signed [CORR_WIDTH-1:0] icorr_value,
    input  logic [CORR_WIDTH-2:0]        ithreshold,
    output logic                         obusy,
    output logic                         ooverrun,
    input  logic                         iclr_overrun,
    rx_correlator_ctrl_if.master         det
);
    localparam int IW = $clog2(SEQ_COUNT);
    localparam int MW = CORR_WIDTH - 1;
    localparam int CW = ACC_CYCLES > 1 ? $clog2(ACC_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, TRIG, ACCUM, SCAN, DECIDE, REPORT} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   sel_q, sel_d, best_idx_q, best_idx_d;
    logic [MW-1:0]   best_mag_q, best_mag_d, cur_mag;
    logic            best_sign_q, best_sign_d, hit_q, hit_d, ovr_q, ovr_d;
    logic            trig_q, trig_d, valid_q, valid_d, busy_q, busy_d;
    logic [CORR_WIDTH-1:0] neg_v;
    logic            thr_ok;
    logic            first, last;
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
    logic [MW-1:0]   second_q, second_d;
    logic            ratio_ok;
`endif

    // Negating the most negative value overflows into the top bit; that single case saturates.
    assign neg_v   = -icorr_value;
    assign cur_mag = !icorr_value[CORR_WIDTH-1] ? icorr_value[MW-1:0] :
                     neg_v[CORR_WIDTH-1] ? '1 : neg_v[MW-1:0];
    assign first   = sel_q == '0;
    assign last    = sel_q == IW'(SEQ_COUNT - 1);
    assign thr_ok  = best_mag_q >= ithreshold;
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
    // One extra bit keeps 2*second from wrapping.
    assign ratio_ok = {1'b0, best_mag_q} >= {second_q, 1'b0};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        best_idx_d  = best_idx_q;
        best_mag_d  = best_mag_q;
        best_sign_d = best_sign_q;
        hit_d       = hit_q;
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
        second_d    = second_q;
`endif
        ovr_d       = (isample_valid && state_q != IDLE) ? 1'b1 : iclr_overrun ? 1'b0 : ovr_q;
        case (state_q)
            IDLE:    state_d = isample_valid ? TRIG : IDLE;
            TRIG: begin
                cnt_d   = CW'(ACC_CYCLES - 1);
                state_d = ACCUM;
            end
            ACCUM: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? SCAN : ACCUM;
            end
            SCAN: begin
                // Strict compare keeps the lowest index on ties; index 0 seeds the search.
                if (first || cur_mag > best_mag_q) begin
                    best_idx_d  = sel_q;
                    best_mag_d  = cur_mag;
                    best_sign_d = ~icorr_value[CORR_WIDTH-1];
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
                    second_d    = first ? '0 : best_mag_q;
`endif
                end
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
                else if (cur_mag > second_q) begin
                    second_d = cur_mag;
                end
`endif
                sel_d   = last ? '0 : sel_q + 1'b1;
                state_d = last ? DECIDE : SCAN;
            end
            DECIDE: begin
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
                hit_d   = thr_ok && ratio_ok;
`else
                hit_d   = thr_ok;
`endif
                state_d = REPORT;
            end
            REPORT:  state_d = det.idet_ready ? IDLE : REPORT;
            default: state_d = IDLE;
        endcase
        trig_d  = state_d == TRIG;
        valid_d = state_d == REPORT;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge crx_clk) begin
        if (rrx_rst || !erx_en) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            best_idx_q  <= '0;
            best_mag_q  <= '0;
            best_sign_q <= 1'b0;
            hit_q       <= 1'b0;
            ovr_q       <= 1'b0;
            trig_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
            second_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            best_idx_q  <= best_idx_d;
            best_mag_q  <= best_mag_d;
            best_sign_q <= best_sign_d;
            hit_q       <= hit_d;
            ovr_q       <= ovr_d;
            trig_q      <= trig_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
            second_q    <= second_d;
`endif
        end
    end

    assign onew_sample_trig = trig_q;
    assign oseq_sel         = sel_q;
    assign obusy            = busy_q;
    assign ooverrun         = ovr_q;
    assign det.odet_valid   = valid_q;
    assign det.odet_index   = best_idx_q;
    assign det.odet_mag     = best_mag_q;
    assign det.odet_sign    = best_sign_q;
    assign det.odet_hit     = hit_q;
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
    assign det.odet_second_mag = second_q;
`endif
endmodule

// File: tb/tb_rx_correlator_ctrl.sv
// tb_rx_correlator_ctrl: randomized scoreboard bench for rx_correlator_ctrl against a behavioural peak-search model.
module tb_rx_correlator_ctrl;
    localparam longint MAXM = (longint'(1) << 40) - 1;

    typedef struct {
        logic [3:0]  idx;
        logic [39:0] mag;
        logic        sign;
        logic        hit;
        logic [39:0] sec;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst, en, sample, clr, trig, busy, ovr;
    logic [3:0]         sel;
    logic signed [40:0] corr;
    logic [39:0]        thr;
    logic signed [40:0] corr_mem [16];

    exp_t   sb[$];
    int     n_cmp = 0, n_fail = 0;
    longint n = 0, m_t0 = 0;
    bit     m_busy = 0, m_ovr = 0, m_zero = 0;

    always #5 clk = ~clk;

    rx_correlator_ctrl_if det ();

    rx_correlator_ctrl dut (
        .crx_clk         (clk),
        .rrx_rst         (rst),
        .erx_en          (en),
        .isample_valid   (sample),
        .onew_sample_trig(trig),
        .oseq_sel        (sel),
        .icorr_value     (corr),
        .ithreshold      (thr),
        .obusy           (busy),
        .ooverrun        (ovr),
        .iclr_overrun    (clr),
        .det             (det)
    );

    // External result mux modelled as a lookup of the current pattern.
    assign corr = corr_mem[sel];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Strongest magnitude, first index holding it, best of the rest.
    function automatic exp_t ref_model(input logic [39:0] t);
        exp_t   e;
        longint m[16];
        longint mx = -1, sec = 0, v;
        int     w = 0;
        for (int i = 0; i < 16; i++) begin
            v    = corr_mem[i];
            m[i] = v < 0 ? -v : v;
            if (m[i] > MAXM) m[i] = MAXM;
            if (m[i] > mx) mx = m[i];
        end
        for (int i = 15; i >= 0; i--) if (m[i] == mx) w = i;
        for (int i = 0; i < 16; i++) if (i != w && m[i] > sec) sec = m[i];
        v      = corr_mem[w];
        e.idx  = 4'(w);
        e.mag  = 40'(mx);
        e.sign = v >= 0;
        e.sec  = 40'(sec);
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
        e.hit  = mx >= longint'(t) && mx >= 2 * sec;
`else
        e.hit  = mx >= longint'(t);
`endif
        return e;
    endfunction

    // An input seen at negedge n is captured at the next posedge; an output that
    // changes k edges after that capture is seen at negedge n+k+1.
    always @(negedge clk) begin : mon
        exp_t e;
        bit   hs;
        n++;
        if (m_zero) begin
            check("reset_zero", {trig, busy, ovr, det.odet_valid, det.odet_sign, det.odet_hit,
                                 sel, det.odet_index, det.odet_mag}, 64'd0);
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
            check("reset_second", det.odet_second_mag, 64'd0);
`endif
        end else begin
            check("trig", trig, m_busy && n == m_t0 + 1);
            check("busy", busy, m_busy);
            check("valid", det.odet_valid, m_busy && n >= m_t0 + 83);
            check("overrun", ovr, m_ovr);
            check("seq_sel", sel, (m_busy && n >= m_t0 + 66 && n <= m_t0 + 81) ? n - m_t0 - 66 : 0);
            if (det.odet_valid) begin
                if (sb.size() == 0) check("report_unexpected", det.odet_valid, 64'd0);
                else begin
                    e = sb[0];
                    check("det_index", det.odet_index, e.idx);
                    check("det_mag", det.odet_mag, e.mag);
                    check("det_sign", det.odet_sign, e.sign);
                    check("det_hit", det.odet_hit, e.hit);
`ifdef RX_CORR_CTRL_PEAK_RATIO_EN
                    check("det_second", det.odet_second_mag, e.sec);
`endif
                end
            end
        end
        if (rst || !en) begin
            m_zero = 1;
            m_busy = 0;
            m_ovr  = 0;
            sb.delete();
        end else begin
            m_zero = 0;
            hs     = m_busy && n >= m_t0 + 83 && det.idet_ready;
            if (sample && m_busy) m_ovr = 1;
            else if (clr) m_ovr = 0;
            if (hs) begin
                m_busy = 0;
                if (sb.size() != 0) void'(sb.pop_front());
            end else if (sample && !m_busy) begin
                m_busy = 1;
                m_t0   = n;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic signed [40:0] v);
        for (int i = 0; i < 16; i++) corr_mem[i] = v;
    endtask

    task automatic rand_fill(input int mode);
        logic signed [40:0] v;
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: corr_mem[i] = 41'({$urandom, $urandom});
                1: begin
                    v = 41'($urandom_range(0, 4) * 1000);
                    corr_mem[i] = $urandom_range(0, 1) ? -v : v;
                end
                default: begin
                    v = $urandom_range(0, 3) == 0 ? {1'b1, 40'd0} :
                        $urandom_range(0, 2) == 0 ? {1'b0, {40{1'b1}}} : 41'($urandom_range(0, 99999));
                    corr_mem[i] = (v != {1'b1, 40'd0} && $urandom_range(0, 1)) ? -v : v;
                end
            endcase
        end
    endtask

    // rdly < 0: ready already high when the report appears; otherwise ready stays low rdly clocks.
    task automatic run_txn(input logic [39:0] t, input int rdly, input int ovr_off,
                           input int abort_off, input bit b2b);
        thr    = t;
        sample = 1;
        sb.push_back(ref_model(t));
        tick;
        sample = 0;
        for (int k = 1; k <= 80; k++) begin
            tick;
            sample = k == ovr_off;
            clr    = k == ovr_off ? 1'($urandom_range(0, 1)) : 1'b0;
            en     = k != abort_off;
            det.idet_ready = k == 80 ? rdly < 0 : 1'($urandom_range(0, 1));
            if (k == abort_off) begin
                tick;
                en = 1;
                sample = 0;
                clr = 0;
                det.idet_ready = 0;
                return;
            end
        end
        for (int w = 0; w < 20 && !det.odet_valid; w++) tick;
        check("valid_timeout", det.odet_valid, 64'd1);
        repeat (rdly > 0 ? rdly : 0) tick;
        det.idet_ready = 1;
        sample = b2b;
        tick;
        det.idet_ready = 0;
        sample = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run still active at %0t, required finish before 1000000", $time);
        $fatal(1);
    end

    initial begin
        rst = 1; en = 1; sample = 0; clr = 0; thr = '0; det.idet_ready = 0;
        set_all('0);
        repeat (3) tick;
        rst = 0;
        tick;

        set_all(41'sd1000); corr_mem[5] = -41'sd300000;
        run_txn(40'd200000, -1, 0, 0, 0);

        set_all(41'sd100); corr_mem[3] = 41'sd5000; corr_mem[9] = 41'sd5000;
        run_txn(40'd4000, 10, 0, 0, 0);

        set_all(41'sd7); corr_mem[0] = {1'b1, 40'd0};
        run_txn({40{1'b1}}, 0, 0, 0, 0);
        set_all(41'sd10);
        run_txn(40'd11, 2, 0, 0, 0);

        rand_fill(1);
        run_txn(40'd2000, 0, 20, 0, 0);
        clr = 1; tick; clr = 0; tick;
        rand_fill(2);
        run_txn(40'd1000, 0, 30, 0, 0);
        rand_fill(1);
        run_txn(40'd1000, 0, 0, 70, 0);
        tick;

        set_all('0); corr_mem[2] = 41'sd1000; corr_mem[7] = 41'sd600;
        run_txn(40'd500, 1, 0, 0, 0);
        corr_mem[7] = -41'sd500;
        run_txn(40'd500, 1, 0, 0, 1);
        clr = 1; tick; clr = 0;

        for (int r = 0; r < 30; r++) begin
            int mode, sel_r;
            mode  = $urandom_range(0, 2);
            sel_r = $urandom_range(0, 9);
            rand_fill(mode);
            run_txn(mode == 0 ? 40'({$urandom, $urandom}) : 40'($urandom_range(0, 5000)),
                    int'($urandom_range(0, 6)) - 1,
                    sel_r < 3 ? int'($urandom_range(1, 79)) : 0,
                    sel_r == 3 ? int'($urandom_range(1, 79)) : 0,
                    sel_r >= 8);
            if ($urandom_range(0, 1)) begin
                clr = 1; tick; clr = 0;
            end
        end

        repeat (3) tick;
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
